// File: rtl/bus_interconnect.sv
// bus_interconnect: single-master, N-slave bus interconnect with a
// configurable address map and registered slave strobes. Unmapped accesses
// end in a bus error. Defining BUS_TIMEOUT_EN adds an access timeout that
// also ends in a bus error; without it ACCESS waits for the slave forever.
module bus_interconnect #(
    parameter int NSLAVES  = 4,
    parameter int ADDR_W   = 24,
    parameter int DATA_W   = 16,
    parameter int SLAVE_AW = 18,
    parameter logic [NSLAVES*ADDR_W-1:0] BASE = '0,
    parameter logic [NSLAVES*ADDR_W-1:0] MASK = '0,
    parameter int TIMEOUT  = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDR_W-1:0]            m_addr,
    input  logic [DATA_W-1:0]            m_wdata,
    output logic [DATA_W-1:0]            m_rdata,
    input  logic                         m_uds,
    input  logic                         m_lds,
    input  logic                         m_rw,
    output logic                         m_ack,
    output logic                         m_berr,
    output logic [ADDR_W-1:0]            err_addr,
    output logic [NSLAVES*SLAVE_AW-1:0]  s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    input  logic [NSLAVES*DATA_W-1:0]    s_rdata,
    output logic [NSLAVES-1:0]           s_uds,
    output logic [NSLAVES-1:0]           s_lds,
    output logic                         s_rw,
    input  logic [NSLAVES-1:0]           s_ack
);

    localparam int SEL_W = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   w_sel;
    logic [NSLAVES-1:0] w_onehot;
    logic               w_hit;
    logic               w_req;
    logic               w_ack_sel;
    logic               w_timeout;
    logic [DATA_W-1:0]  w_rdata;

    // Address decode: lowest-index matching slave wins.
    always_comb begin
        w_hit    = 1'b0;
        w_sel    = '0;
        w_onehot = '0;
        for (int unsigned i = 0; i < NSLAVES; i++) begin
            if (!w_hit && ((m_addr & MASK[i*ADDR_W +: ADDR_W]) == BASE[i*ADDR_W +: ADDR_W])) begin
                w_hit       = 1'b1;
                w_sel       = i[SEL_W-1:0];
                w_onehot[i] = 1'b1;
            end
        end
    end

    // Read-data mux for the selected slave.
    always_comb begin
        w_rdata = '0;
        for (int unsigned i = 0; i < NSLAVES; i++) begin
            if (i[SEL_W-1:0] == r_sel) begin
                w_rdata = s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_req     = m_uds | m_lds;
    assign w_ack_sel = s_ack[r_sel];

`ifdef BUS_TIMEOUT_EN
    logic [15:0]       r_cnt;
    logic [ADDR_W-1:0] r_addr;

    // Access cycle counter, zero whenever not in ACCESS.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_state != ACCESS) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // Full master address of the access in flight, reported on timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr <= '0;
        end else if (r_state == IDLE && w_req && w_hit) begin
            r_addr <= m_addr;
        end
    end

    // Expiry lands on edge E0+TIMEOUT: the count seen at edge Ek is k-1.
    assign w_timeout = (r_state == ACCESS) && (r_cnt == 16'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a slave ack takes priority over timeout expiry.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_req) w_next = w_hit ? ACCESS : DONE;
            ACCESS:  if (w_ack_sel || w_timeout) w_next = DONE;
            DONE:    if (!w_req) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Registered outputs, updated alongside the state transitions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel    <= '0;
            m_ack    <= 1'b0;
            m_berr   <= 1'b0;
            m_rdata  <= '0;
            err_addr <= '0;
            s_addr   <= '0;
            s_wdata  <= '0;
            s_uds    <= '0;
            s_lds    <= '0;
            s_rw     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req && w_hit) begin
                        r_sel   <= w_sel;
                        s_addr  <= {NSLAVES{m_addr[SLAVE_AW-1:0]}};
                        s_wdata <= m_wdata;
                        s_rw    <= m_rw;
                        s_uds   <= w_onehot & {NSLAVES{m_uds}};
                        s_lds   <= w_onehot & {NSLAVES{m_lds}};
                    end else if (w_req) begin
                        m_berr   <= 1'b1;
                        err_addr <= m_addr;
                    end
                end
                ACCESS: begin
                    if (w_ack_sel) begin
                        s_uds <= '0;
                        s_lds <= '0;
                        m_ack <= 1'b1;
                        if (s_rw) m_rdata <= w_rdata;
                    end else if (w_timeout) begin
                        s_uds  <= '0;
                        s_lds  <= '0;
                        m_berr <= 1'b1;
`ifdef BUS_TIMEOUT_EN
                        err_addr <= r_addr;
`endif
                    end
                end
                DONE: begin
                    if (!w_req) begin
                        m_ack  <= 1'b0;
                        m_berr <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
